jtag_scan_sequencer: RTL

- Synthesizable JTAG master that applies one scan test vector per start pulse to a downstream TAP.
- Per test: loads an instruction into IR, shifts a parametrised-length vector into DR, then shifts out a parametrised-length response and compares it against an expected response.
- Sits in the user project between a Wishbone-facing register block (vectors, control) and the mprj_io pins carrying tck/tms/tdi/tdo/trst.
- Generalises the fixed 4-bit IR / 268-bit load / 405-bit read flow to any widths, with two DR modes and error statistics.

---
 rtl/jtag_scan_sequencer_if.sv | 10 +
 rtl/jtag_scan_sequencer.sv | 136 +++++++++++++
 2 files changed

// File: rtl/jtag_scan_sequencer_if.sv
// jtag_scan_sequencer_if: JTAG pin bundle between the scan sequencer (master) and a downstream TAP (slave).
interface jtag_scan_sequencer_if;
   logic tck;
   logic tms;
   logic tdi;
   logic tdo;
   logic trst_n;
   modport master (output tck, tms, tdi, trst_n, input tdo);
   modport slave (input tck, tms, tdi, trst_n, output tdo);
endinterface

// File: rtl/jtag_scan_sequencer.sv
// jtag_scan_sequencer: per start pulse loads IR, shifts a stimulus into DR, reads back and scores the response.
// Define JTAG_SEQ_RESP_MASK_EN to add resp_mask, whose zero bits mark don't-care response bits.
module jtag_scan_sequencer #(
   parameter int IR_W = 4,
   parameter int VEC_W = 268,
   parameter int RESP_W = 405,
   parameter int TCK_DIV = 2,
   parameter int ERR_W = 16
) (
   input  logic                     wb_clk_i,
   input  logic                     wb_rst_i,
   input  logic                     start,
   input  logic                     tap_reset,
   input  logic                     dr_mode,
   input  logic [IR_W-1:0]          instr,
   input  logic [VEC_W-1:0]         vector,
   input  logic [RESP_W-1:0]        golden,
`ifdef JTAG_SEQ_RESP_MASK_EN
   input  logic [RESP_W-1:0]        resp_mask,
`endif
   output logic                     busy,
   output logic                     done,
   output logic                     pass,
   output logic [ERR_W-1:0]         err_cnt,
   output logic [$clog2(RESP_W):0]  first_err,
   jtag_scan_sequencer_if.master    jtag
);
   localparam int M1 = IR_W > VEC_W ? IR_W : VEC_W;
   localparam int M2 = M1 > RESP_W ? M1 : RESP_W;
   localparam int MAX_LEN = M2 > 6 ? M2 : 6;
   localparam int CNT_W = $clog2(MAX_LEN);
   localparam int DIV_W = TCK_DIV > 1 ? $clog2(TCK_DIV) : 1;
   localparam int FE_W = $clog2(RESP_W) + 1;
   // Encoding order is the test order, so each phase advances to state + 1.
   typedef enum logic [3:0] {
      IDLE, TLR, IR_SEL, IR_SHIFT, IR_EXIT, DR_SEL, DR_LOAD, DR_MID, DR_READ, DR_EXIT, DONE
   } state_t;
   state_t state, state_n;
   logic [CNT_W-1:0] cnt, lm1;
   logic [DIV_W-1:0] div;
   logic tck_q, trst_q, mode_q, tick, rise, fall, last, tms, tdi, miss;
   logic [IR_W-1:0] instr_q;
   logic [VEC_W-1:0] vector_q;
   logic [RESP_W-1:0] golden_q;
`ifdef JTAG_SEQ_RESP_MASK_EN
   logic [RESP_W-1:0] mask_q;
   assign miss = mask_q[0] & (jtag.tdo ^ golden_q[0]);
`else
   assign miss = jtag.tdo ^ golden_q[0];
`endif
   assign busy = state != IDLE && state != DONE;
   assign done = state == DONE;
   assign tick = busy && div == DIV_W'(TCK_DIV - 1);
   assign rise = tick && !tck_q;
   assign fall = tick && tck_q;
   assign last = cnt == lm1;
   assign jtag.tck = tck_q;
   assign jtag.tms = tms;
   assign jtag.tdi = tdi;
   assign jtag.trst_n = trst_q;
   always_comb begin
      state_n = state;
      lm1 = '0;
      tms = 1'b1;
      tdi = 1'b0;
      case (state)
         TLR:      begin lm1 = CNT_W'(5); tms = cnt < CNT_W'(5); end
         IR_SEL:   begin lm1 = CNT_W'(3); tms = cnt < CNT_W'(2); end
         IR_SHIFT: begin lm1 = CNT_W'(IR_W - 1); tms = cnt == lm1; tdi = instr_q[0]; end
         IR_EXIT:  begin lm1 = CNT_W'(1); tms = cnt == '0; end
         DR_SEL:   begin lm1 = CNT_W'(2); tms = cnt == '0; end
         DR_LOAD:  begin lm1 = CNT_W'(VEC_W - 1); tms = cnt == lm1; tdi = vector_q[0]; end
         DR_MID:   begin
            lm1 = mode_q ? CNT_W'(4) : CNT_W'(2);
            tms = mode_q ? (cnt == '0 || cnt == CNT_W'(2)) : cnt == CNT_W'(1);
         end
         DR_READ:  begin lm1 = CNT_W'(RESP_W - 1); tms = cnt == lm1; end
         DR_EXIT:  begin lm1 = CNT_W'(1); tms = cnt == '0; end
         default: ;
      endcase
      if (state == IDLE) state_n = start ? (tap_reset ? TLR : IR_SEL) : IDLE;
      else if (state == DONE) state_n = IDLE;
      else if (fall && cnt == lm1) state_n = state_t'(state + 4'd1);
   end
   always_ff @(posedge wb_clk_i or posedge wb_rst_i)
      if (wb_rst_i) state <= IDLE;
      else state <= state_n;
   always_ff @(posedge wb_clk_i or posedge wb_rst_i)
      if (wb_rst_i) begin
         cnt <= '0;
         div <= '0;
         tck_q <= 1'b0;
         trst_q <= 1'b0;
         mode_q <= 1'b0;
         instr_q <= '0;
         vector_q <= '0;
         golden_q <= '0;
`ifdef JTAG_SEQ_RESP_MASK_EN
         mask_q <= '0;
`endif
         pass <= 1'b0;
         err_cnt <= '0;
         first_err <= '1;
      end else begin
         trst_q <= 1'b1;
         div <= tick || !busy ? '0 : div + 1'b1;
         if (tick) tck_q <= !tck_q;
         if (state == IDLE && start) begin
            mode_q <= dr_mode;
            instr_q <= instr;
            vector_q <= vector;
            golden_q <= golden;
`ifdef JTAG_SEQ_RESP_MASK_EN
            mask_q <= resp_mask;
`endif
            pass <= 1'b0;
            err_cnt <= '0;
            first_err <= '1;
         end
         // Stimulus bits present on tdi[0] and advance on the falling tick.
         if (fall) begin
            cnt <= last ? '0 : cnt + 1'b1;
            if (state == IR_SHIFT) instr_q <= instr_q >> 1;
            if (state == DR_LOAD) vector_q <= vector_q >> 1;
            if (state == DR_EXIT && last) pass <= err_cnt == '0;
         end
         if (rise && state == DR_READ) begin
            golden_q <= golden_q >> 1;
`ifdef JTAG_SEQ_RESP_MASK_EN
            mask_q <= mask_q >> 1;
`endif
            if (miss && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            if (miss && first_err == '1) first_err <= FE_W'(cnt);
         end
      end
endmodule
